// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states, word width
// and the checksum seed.
package program_loader_pkg;

  localparam int WORD_W = 16;
  localparam logic [7:0] CSUM_SEED = 8'h00;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/program_loader_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count would reach TIMEOUT.
module loader_timeout #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Asserted on the edge that would take the count to TIMEOUT, so the FSM
  // can move to ERROR on that same edge and drop any byte arriving with it.
  assign tc = en && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/program_loader.sv
// Assembles a length-prefixed, XOR-checksummed byte stream into 16-bit RAM
// writes and holds the CPU in reset until the image is verified.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256,
  parameter int          TIMEOUT   = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [15:0]       ram_address,
  output logic [WORD_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  state_t      state_reg, state_next;
  logic [15:0] length_reg;
  logic [15:0] word_count_reg;
  logic [7:0]  csum_reg;
  logic [15:0] length_rx;
  logic        count_en;
  logic        tc;
  logic        accept;

  assign count_en  = (state_reg == LEN_LO) || (state_reg == DATA_HI) ||
                     (state_reg == DATA_LO) || (state_reg == CHECK);
  // A byte coinciding with the watchdog expiring is dropped.
  assign accept    = rx_valid && !tc &&
                     (state_reg != DONE) && (state_reg != ERROR);
  assign length_rx = {length_reg[15:8], rx_data};

  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (count_en),
    .tc (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LEN_HI;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (tc) begin
      state_next = ERROR;
    end else if (accept) begin
      case (state_reg)
        LEN_HI:  state_next = LEN_LO;
        LEN_LO: begin
          if (length_rx > MAX_LEN) begin
            state_next = ERROR;
          end else if (length_rx == 16'd0) begin
            state_next = CHECK;
          end else begin
            state_next = DATA_HI;
          end
        end
        DATA_HI: state_next = DATA_LO;
        DATA_LO: begin
          if (word_count_reg + 16'd1 == length_reg) begin
            state_next = CHECK;
          end else begin
            state_next = DATA_HI;
          end
        end
        CHECK:   state_next = (rx_data == csum_reg) ? DONE : ERROR;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_address    <= BASE_ADDR;
      ram_data       <= '0;
      ram_wren       <= 1'b0;
      csum_reg       <= CSUM_SEED;
      word_count_reg <= '0;
      length_reg     <= '0;
    end else begin
      ram_wren <= accept && (state_reg == DATA_LO);
      // Address advances after the strobe so it is stable during the write.
      if (ram_wren) begin
        ram_address <= ram_address + 16'd1;
      end
      if (accept && (state_reg != CHECK)) begin
        csum_reg <= csum_reg ^ rx_data;
      end
      if (accept) begin
        case (state_reg)
          LEN_HI:  length_reg[15:8] <= rx_data;
          LEN_LO:  length_reg[7:0]  <= rx_data;
          DATA_HI: ram_data[15:8]   <= rx_data;
          DATA_LO: begin
            ram_data[7:0]  <= rx_data;
            word_count_reg <= word_count_reg + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_rst    = (state_reg != DONE);
  assign load_done  = (state_reg == DONE);
  assign load_error = (state_reg == ERROR);

endmodule
